// File: rtl/universal_shift_reg.sv
// Universal shift register with load, shift, rotate, clear and invert operations.
// It also keeps a saturating count of shifts since the last load or clear.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic                       sout_l,
    output logic                       sout_r,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The bit entering at each end is either sin (shift) or the bit leaving at the other end (rotate).
    logic fill_lo;
    logic fill_hi;
    logic [WIDTH-1:0] left_val;
    logic [WIDTH-1:0] right_val;

    assign fill_lo = (mode == MODE_SHL) ? sin : q_reg[WIDTH-1];
    assign fill_hi = (mode == MODE_SHR) ? sin : q_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            if (gi == 0) begin : g_lo
                assign left_val[gi] = fill_lo;
            end else begin : g_lo_mid
                assign left_val[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_hi
                assign right_val[gi] = fill_hi;
            end else begin : g_hi_mid
                assign right_val[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        q_next   = q_reg;
        cnt_next = cnt_reg;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next = q_reg;
                MODE_LOAD: begin
                    q_next   = d;
                    cnt_next = '0;
                end
                MODE_SHL, MODE_ROL: begin
                    q_next = left_val;
                    if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
                end
                MODE_SHR, MODE_ROR: begin
                    q_next = right_val;
                    if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
                end
                MODE_CLR: begin
                    q_next   = '0;
                    cnt_next = '0;
                end
                MODE_INV: q_next = ~q_reg;
                default:  q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= RESET_VAL;
            cnt_reg <= '0;
        end else begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign q      = q_reg;
    assign q_bar  = ~q_reg;
    assign sout_l = q_reg[WIDTH-1];
    assign sout_r = q_reg[0];
    assign cnt    = cnt_reg;
    assign done   = (cnt_reg == CNT_MAX);

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 Parameters SHALL be:
  - WIDTH, default 8, register width in bits (WIDTH >= 2).
  - RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Ports SHALL be:
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous active-high reset
  - en  in  1  operation enable
  - mode  in  3  operation select
  - d  in  WIDTH  parallel load data
  - sin  in  1  serial input bit
  - q  out  WIDTH  register contents
  - q_bar  out  WIDTH  bitwise complement of q
  - sout_l  out  1  q[WIDTH-1], the bit leaving on a left shift
  - sout_r  out  1  q[0], the bit leaving on a right shift
  - cnt  out  clog2(WIDTH+1)  shifts since last load or clear
  - done  out  1  high when cnt == WIDTH

Function
REQ-004 q and cnt SHALL be registers updated only on the rising edge of clk.
REQ-005 q_bar, sout_l, sout_r and done SHALL be combinational from q and cnt, so they update in the same cycle as q.
REQ-006 When en is 0, q and cnt SHALL hold regardless of mode, d or sin.
REQ-007 When en is 1, mode SHALL select the next value of q:
  - 000 hold: q unchanged.
  - 001 load: q = d.
  - 010 shift left: q = {q[WIDTH-2:0], sin}.
  - 011 shift right: q = {sin, q[WIDTH-1:1]}.
  - 100 rotate left: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q = {q[0], q[WIDTH-1:1]}.
  - 110 clear: q = 0.
  - 111 invert: q = ~q.
REQ-008 When en is 1, cnt SHALL update as follows:
  - Load and clear set cnt to 0.
  - Modes 010 to 101 increment cnt, saturating at WIDTH.
  - Hold and invert leave cnt unchanged.
REQ-009 Once cnt reaches WIDTH, further shifts or rotates SHALL leave cnt at WIDTH and done high; done SHALL clear only on load, clear or reset.
REQ-010 Latency SHALL be one cycle: the value of q selected at edge N SHALL be visible on q and q_bar immediately after edge N.
REQ-011 The serial input sin SHALL be sampled only in modes 010 and 011; d SHALL be sampled only in mode 001.
REQ-012 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-013 When rst is high at a rising clk edge, the block SHALL set q = RESET_VAL and cnt = 0, overriding en and mode.
REQ-014 After reset, q_bar SHALL equal ~RESET_VAL, done SHALL be 0, sout_l SHALL be RESET_VAL[WIDTH-1] and sout_r SHALL be RESET_VAL[0].
REQ-015 Reset asserted mid-sequence, including while done is high, SHALL take effect on the next edge with no residual count.
REQ-016 Output values before the first reset edge are unspecified; the bench SHALL apply rst for at least 2 cycles.

Verification (WIDTH=8, RESET_VAL=0)
REQ-017 Reset, then load:
  - rst for 2 cycles -> q=00, q_bar=FF, cnt=0, done=0.
  - en=1, mode=001, d=A5 -> next cycle q=A5, q_bar=5A.
REQ-018 Shift left to saturation:
  - From q=A5, 8 cycles of mode=010 with sin=1 -> q=FF, cnt=8, done=1.
  - A 9th shift -> cnt stays 8.
  - The sout_l sequence before each edge is 1,0,1,0,0,1,0,1.
REQ-019 Rotate right:
  - Load 81, then mode=101 for 1 cycle -> q=C0, cnt=1.
  - 7 more cycles -> q=81, done=1.
REQ-020 Enable gating:
  - q=3C, en=0, mode=110 for 5 cycles -> q=3C, cnt unchanged.
  - en=1, mode=111 -> q=C3.
REQ-021 Shift right, then reset:
  - Load F0, then mode=011 with sin=0 for 3 cycles -> q=1E, cnt=3.
  - rst for 1 cycle with en=1, mode=001, d=FF -> q=00, cnt=0.
REQ-022 Randomised run:
  - 500 cycles of random en, mode, d, sin, compared cycle by cycle against a reference model.
  - q_bar == ~q checked every cycle.
